mfp_ahb_master_arbiter: RTL and testbench

Two-master AHB-Lite arbiter between the MIPSfpga core (master 0) and the UART S-record loader bridge (master 1), driving the single `mfp_ahb` slave fabric. It replaces the static `in_progress` address/control mux with cycle-correct ownership tracking:
- address-phase grant;
- data-phase owner;
- per-master `HREADY`;
- write-data steering.

Either master may then issue transfers safely at any time.

---
 rtl/mfp_ahb_master_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_mfp_ahb_master_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_master_arbiter.sv
// mfp_ahb_master_arbiter
// Two-master AHB-Lite arbiter: master 0 is the MIPSfpga core, master 1 is the
// UART S-record loader bridge. Both share the single mfp_ahb slave fabric.
//
// Ownership is tracked at cycle level:
//   owner_r     - master that owns the address phase
//   dp_valid_r  - a data phase is outstanding on the slave
//   dp_owner_r  - master that owns that outstanding data phase
// Address/control reaches the slave combinationally from the granted master,
// so a hand-over costs no bubble. Write data and responses follow the
// data-phase owner.
//
// Optional feature macro: MFP_ARB_ROUND_ROBIN_EN
//   defined   - round robin: the other master wins every permitted switch point
//   undefined - fixed priority: the loader (master 1) wins over the core
module mfp_ahb_master_arbiter #(
  parameter logic DEF_OWNER = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESETn,

  input  logic [31:0] M0_HADDR,
  input  logic [2:0]  M0_HBURST,
  input  logic        M0_HMASTLOCK,
  input  logic [3:0]  M0_HPROT,
  input  logic [2:0]  M0_HSIZE,
  input  logic [1:0]  M0_HTRANS,
  input  logic [31:0] M0_HWDATA,
  input  logic        M0_HWRITE,
  output logic        M0_HREADY,
  output logic        M0_HRESP,

  input  logic [31:0] M1_HADDR,
  input  logic [2:0]  M1_HBURST,
  input  logic        M1_HMASTLOCK,
  input  logic [3:0]  M1_HPROT,
  input  logic [2:0]  M1_HSIZE,
  input  logic [1:0]  M1_HTRANS,
  input  logic [31:0] M1_HWDATA,
  input  logic        M1_HWRITE,
  output logic        M1_HREADY,
  output logic        M1_HRESP,

  output logic [31:0] HRDATA_M,

  output logic [31:0] S_HADDR,
  output logic [2:0]  S_HBURST,
  output logic        S_HMASTLOCK,
  output logic [3:0]  S_HPROT,
  output logic [2:0]  S_HSIZE,
  output logic [1:0]  S_HTRANS,
  output logic [31:0] S_HWDATA,
  output logic        S_HWRITE,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADY,
  input  logic        S_HRESP,

  output logic        GRANT
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Ownership state
  logic owner_r;
  logic dp_valid_r;
  logic dp_owner_r;

  // Combinational arbitration terms
  logic       req0_s;
  logic       req1_s;
  logic       req_owner_s;
  logic       req_other_s;
  logic [1:0] own_trans_s;
  logic       own_lock_s;
  logic       switch_ok_s;
  logic       win_other_s;
  logic       grant_s;
  logic       grant_req_s;

  // Ready seen by master idx: the data-phase owner and the address-phase
  // grantee track the slave; a denied requester stalls, an idle master
  // sees ready.
  function automatic logic master_ready(
    input logic idx,
    input logic req,
    input logic grant,
    input logic dp_valid,
    input logic dp_owner,
    input logic s_ready
  );
    logic rdy;
    if (dp_valid && (dp_owner == idx)) begin
      rdy = s_ready;
    end else if (grant == idx) begin
      rdy = s_ready;
    end else begin
      rdy = ~req;
    end
    return rdy;
  endfunction

  // A master requests whenever it drives NONSEQ or SEQ
  assign req0_s = M0_HTRANS[1];
  assign req1_s = M1_HTRANS[1];

  // Select the current owner's transfer type, lock and request against the other master's request
  always_comb begin
    own_trans_s = M0_HTRANS;
    own_lock_s  = M0_HMASTLOCK;
    req_owner_s = req0_s;
    req_other_s = req1_s;
    if (owner_r) begin
      own_trans_s = M1_HTRANS;
      own_lock_s  = M1_HMASTLOCK;
      req_owner_s = req1_s;
      req_other_s = req0_s;
    end else begin
      own_trans_s = M0_HTRANS;
      own_lock_s  = M0_HMASTLOCK;
      req_owner_s = req0_s;
      req_other_s = req1_s;
    end
  end

  // Switch only at a clean boundary: slave ready, owner unlocked, owner IDLE
  // or starting a NONSEQ that does not coincide with its own data phase
  always_comb begin
    switch_ok_s = 1'b0;
    if (S_HREADY && !own_lock_s) begin
      case (own_trans_s)
        HTRANS_IDLE:   switch_ok_s = 1'b1;
        HTRANS_NONSEQ: switch_ok_s = ~(dp_valid_r & (dp_owner_r == owner_r));
        default:       switch_ok_s = 1'b0;
      endcase
    end else begin
      switch_ok_s = 1'b0;
    end
  end

`ifdef MFP_ARB_ROUND_ROBIN_EN
  // Round robin: the waiting master always wins a permitted switch point
  assign win_other_s = 1'b1;
`else
  // Fixed priority: the loader takes the bus from the core; the core only
  // takes the bus back once the loader is idle
  assign win_other_s = (owner_r == 1'b0) | ~req_owner_s;
`endif

  // Address-phase grant and the granted master's request
  always_comb begin
    grant_s     = owner_r;
    grant_req_s = req0_s;
    if (switch_ok_s && req_other_s && win_other_s) begin
      grant_s = ~owner_r;
    end else begin
      grant_s = owner_r;
    end
    if (grant_s) begin
      grant_req_s = req1_s;
    end else begin
      grant_req_s = req0_s;
    end
  end

  assign GRANT = grant_s;

  // Ownership registers advance only when the slave accepts the current cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_r    <= DEF_OWNER;
      dp_valid_r <= 1'b0;
      dp_owner_r <= DEF_OWNER;
    end else if (S_HREADY) begin
      owner_r    <= grant_s;
      dp_valid_r <= grant_req_s;
      dp_owner_r <= grant_s;
    end
  end

  // Slave address/control taken straight from the granted master
  always_comb begin
    S_HADDR     = M0_HADDR;
    S_HBURST    = M0_HBURST;
    S_HMASTLOCK = M0_HMASTLOCK;
    S_HPROT     = M0_HPROT;
    S_HSIZE     = M0_HSIZE;
    S_HTRANS    = M0_HTRANS;
    S_HWRITE    = M0_HWRITE;
    if (grant_s) begin
      S_HADDR     = M1_HADDR;
      S_HBURST    = M1_HBURST;
      S_HMASTLOCK = M1_HMASTLOCK;
      S_HPROT     = M1_HPROT;
      S_HSIZE     = M1_HSIZE;
      S_HTRANS    = M1_HTRANS;
      S_HWRITE    = M1_HWRITE;
    end else begin
      S_HADDR     = M0_HADDR;
      S_HBURST    = M0_HBURST;
      S_HMASTLOCK = M0_HMASTLOCK;
      S_HPROT     = M0_HPROT;
      S_HSIZE     = M0_HSIZE;
      S_HTRANS    = M0_HTRANS;
      S_HWRITE    = M0_HWRITE;
    end
  end

  // Write data belongs to the data phase, so it follows the data-phase owner
  always_comb begin
    S_HWDATA = M0_HWDATA;
    if (dp_owner_r) begin
      S_HWDATA = M1_HWDATA;
    end else begin
      S_HWDATA = M0_HWDATA;
    end
  end

  // Responses go only to the master whose data phase is outstanding
  always_comb begin
    M0_HRESP = 1'b0;
    M1_HRESP = 1'b0;
    if (dp_valid_r && !dp_owner_r) begin
      M0_HRESP = S_HRESP;
    end else if (dp_valid_r && dp_owner_r) begin
      M1_HRESP = S_HRESP;
    end else begin
      M0_HRESP = 1'b0;
      M1_HRESP = 1'b0;
    end
  end

  // Per-master ready and broadcast read data
  always_comb begin
    M0_HREADY = master_ready(1'b0, req0_s, grant_s, dp_valid_r, dp_owner_r, S_HREADY);
    M1_HREADY = master_ready(1'b1, req1_s, grant_s, dp_valid_r, dp_owner_r, S_HREADY);
    HRDATA_M  = S_HRDATA;
  end

endmodule

// File: tb/tb_mfp_ahb_master_arbiter.sv
// Directed bench for mfp_ahb_master_arbiter: a table of per-cycle vectors for
// the basic and contention flows, plus hand-written sequences for wait states,
// locked transfers, asynchronous reset and the priority policy.
module tb_mfp_ahb_master_arbiter;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] NSQ = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [2:0]  M0_HBURST, M1_HBURST;
  logic        M0_HMASTLOCK, M1_HMASTLOCK;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        M0_HWRITE, M1_HWRITE;
  logic        M0_HREADY, M1_HREADY;
  logic        M0_HRESP, M1_HRESP;
  logic [31:0] HRDATA_M;
  logic [31:0] S_HADDR;
  logic [2:0]  S_HBURST;
  logic        S_HMASTLOCK;
  logic [3:0]  S_HPROT;
  logic [2:0]  S_HSIZE;
  logic [1:0]  S_HTRANS;
  logic [31:0] S_HWDATA;
  logic        S_HWRITE;
  logic [31:0] S_HRDATA;
  logic        S_HREADY;
  logic        S_HRESP;
  logic        GRANT;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [1:0]  m0_trans;
    logic [31:0] m0_addr;
    logic        m0_write;
    logic        m0_lock;
    logic [1:0]  m1_trans;
    logic [31:0] m1_addr;
    logic        m1_write;
    logic        m1_lock;
    logic        s_ready;
    logic        s_resp;
    logic        e_grant;
    logic        e_m0_rdy;
    logic        e_m1_rdy;
    logic        e_m0_resp;
    logic        e_m1_resp;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        e_write;
    logic        e_wsel;
  } vec_t;

  vec_t tbl [10];

  mfp_ahb_master_arbiter #(.DEF_OWNER(1'b0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HBURST(M0_HBURST), .M0_HMASTLOCK(M0_HMASTLOCK),
    .M0_HPROT(M0_HPROT), .M0_HSIZE(M0_HSIZE), .M0_HTRANS(M0_HTRANS),
    .M0_HWDATA(M0_HWDATA), .M0_HWRITE(M0_HWRITE), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HBURST(M1_HBURST), .M1_HMASTLOCK(M1_HMASTLOCK),
    .M1_HPROT(M1_HPROT), .M1_HSIZE(M1_HSIZE), .M1_HTRANS(M1_HTRANS),
    .M1_HWDATA(M1_HWDATA), .M1_HWRITE(M1_HWRITE), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .HRDATA_M(HRDATA_M),
    .S_HADDR(S_HADDR), .S_HBURST(S_HBURST), .S_HMASTLOCK(S_HMASTLOCK), .S_HPROT(S_HPROT),
    .S_HSIZE(S_HSIZE), .S_HTRANS(S_HTRANS), .S_HWDATA(S_HWDATA), .S_HWRITE(S_HWRITE),
    .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY), .S_HRESP(S_HRESP),
    .GRANT(GRANT)
  );

  // Free-running bus clock
  always #5 HCLK = ~HCLK;

  function automatic vec_t mk(
    input logic [1:0] t0, input logic [31:0] a0, input logic w0, input logic l0,
    input logic [1:0] t1, input logic [31:0] a1, input logic w1, input logic l1,
    input logic rdy, input logic rsp,
    input logic g, input logic r0, input logic r1, input logic p0, input logic p1,
    input logic [1:0] et, input logic [31:0] ea, input logic ew, input logic ws
  );
    vec_t v;
    v.m0_trans = t0; v.m0_addr = a0; v.m0_write = w0; v.m0_lock = l0;
    v.m1_trans = t1; v.m1_addr = a1; v.m1_write = w1; v.m1_lock = l1;
    v.s_ready = rdy; v.s_resp = rsp;
    v.e_grant = g; v.e_m0_rdy = r0; v.e_m1_rdy = r1; v.e_m0_resp = p0; v.e_m1_resp = p1;
    v.e_trans = et; v.e_addr = ea; v.e_write = ew; v.e_wsel = ws;
    return v;
  endfunction

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s (step %0d): got %h, want %h", name, tag, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int tag);
    M0_HTRANS = v.m0_trans; M0_HADDR = v.m0_addr; M0_HWRITE = v.m0_write; M0_HMASTLOCK = v.m0_lock;
    M1_HTRANS = v.m1_trans; M1_HADDR = v.m1_addr; M1_HWRITE = v.m1_write; M1_HMASTLOCK = v.m1_lock;
    M0_HWDATA = {16'hC0C0, tag[15:0]};
    M1_HWDATA = {16'h1D1D, tag[15:0]};
    M0_HBURST = 3'b000; M1_HBURST = 3'b001;
    M0_HPROT  = 4'b0011; M1_HPROT = 4'b0001;
    M0_HSIZE  = 3'b010; M1_HSIZE = 3'b000;
    S_HRDATA  = {16'hDA7A, tag[15:0]};
    S_HREADY  = v.s_ready;
    S_HRESP   = v.s_resp;
  endtask

  task automatic check(input vec_t v, input int tag);
    chk("grant",     tag, 32'(GRANT),       32'(v.e_grant));
    chk("m0_hready", tag, 32'(M0_HREADY),   32'(v.e_m0_rdy));
    chk("m1_hready", tag, 32'(M1_HREADY),   32'(v.e_m1_rdy));
    chk("m0_hresp",  tag, 32'(M0_HRESP),    32'(v.e_m0_resp));
    chk("m1_hresp",  tag, 32'(M1_HRESP),    32'(v.e_m1_resp));
    chk("s_htrans",  tag, 32'(S_HTRANS),    32'(v.e_trans));
    chk("s_haddr",   tag, S_HADDR,          v.e_addr);
    chk("s_hwrite",  tag, 32'(S_HWRITE),    32'(v.e_write));
    chk("s_hwdata",  tag, S_HWDATA,         v.e_wsel ? {16'h1D1D, tag[15:0]} : {16'hC0C0, tag[15:0]});
    chk("s_hsize",   tag, 32'(S_HSIZE),     v.e_grant ? 32'd0 : 32'd2);
    chk("s_hprot",   tag, 32'(S_HPROT),     v.e_grant ? 32'd1 : 32'd3);
    chk("s_hlock",   tag, 32'(S_HMASTLOCK), 32'(v.e_grant ? v.m1_lock : v.m0_lock));
    chk("hrdata_m",  tag, HRDATA_M,         {16'hDA7A, tag[15:0]});
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    @(negedge HCLK);
    drive(v, tag);
    #1;
    check(v, tag);
  endtask

  initial begin
    //           core: trans addr        wr    lock  loader: trans addr    wr    lock  rdy   rsp   | grant m0rdy m1rdy m0rsp m1rsp  s_trans s_addr   wr   wsel
    tbl[0] = mk(IDL, 32'h0000_0000, 1'b0, 1'b0, IDL, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, IDL, 32'h0000_0000, 1'b0, 1'b0);
    tbl[1] = mk(NSQ, 32'h1FC0_0000, 1'b0, 1'b0, IDL, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, 32'h1FC0_0000, 1'b0, 1'b0);
    tbl[2] = mk(NSQ, 32'hBF80_0000, 1'b1, 1'b0, IDL, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, NSQ, 32'hBF80_0000, 1'b1, 1'b0);
    tbl[3] = mk(IDL, 32'hBF80_0000, 1'b0, 1'b0, IDL, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, IDL, 32'hBF80_0000, 1'b0, 1'b0);
    tbl[4] = mk(NSQ, 32'h1000_0000, 1'b0, 1'b0, NSQ, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NSQ, 32'h0000_0010, 1'b1, 1'b0);
    tbl[5] = mk(NSQ, 32'h1000_0000, 1'b0, 1'b0, IDL, 32'h0000_0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, NSQ, 32'h1000_0000, 1'b0, 1'b1);
    tbl[6] = mk(NSQ, 32'h1000_0004, 1'b0, 1'b0, IDL, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, 32'h1000_0004, 1'b0, 1'b0);
    tbl[7] = mk(IDL, 32'h1000_0004, 1'b0, 1'b0, IDL, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, IDL, 32'h1000_0004, 1'b0, 1'b0);
    tbl[8] = mk(IDL, 32'h0000_0000, 1'b0, 1'b0, NSQ, 32'h0000_0020, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, 32'h0000_0020, 1'b1, 1'b0);
    tbl[9] = mk(IDL, 32'h0000_0000, 1'b0, 1'b0, IDL, 32'h0000_0024, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IDL, 32'h0000_0024, 1'b0, 1'b1);

    // Reset with both masters idle; slave response forced high to show it is not routed
    drive(mk(IDL, 32'h0, 1'b0, 1'b0, IDL, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0, IDL, 32'h0, 1'b0, 1'b0), 0);
    repeat (2) @(negedge HCLK);
    #1;
    chk("rst_grant",   0, 32'(GRANT),     32'd0);
    chk("rst_s_htrans",0, 32'(S_HTRANS),  32'd0);
    chk("rst_m0_rdy",  0, 32'(M0_HREADY), 32'd1);
    chk("rst_m1_rdy",  0, 32'(M1_HREADY), 32'd1);
    chk("rst_m0_resp", 0, 32'(M0_HRESP),  32'd0);
    chk("rst_m1_resp", 0, 32'(M1_HRESP),  32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Core read/write, then loader pre-empting back-to-back core NONSEQs
    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], i);
    end

    // Two slave wait states during a core data phase while the loader requests
    run_vec(mk(NSQ, 32'h4000_0000, 1'b0, 1'b0, IDL, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, 32'h4000_0000, 1'b0, 1'b1), 20);
    run_vec(mk(IDL, 32'h4000_0000, 1'b0, 1'b0, NSQ, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDL, 32'h4000_0000, 1'b0, 1'b0), 21);
    run_vec(mk(IDL, 32'h4000_0000, 1'b0, 1'b0, NSQ, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, IDL, 32'h4000_0000, 1'b0, 1'b0), 22);
    run_vec(mk(IDL, 32'h4000_0000, 1'b0, 1'b0, NSQ, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, 32'h0000_0040, 1'b1, 1'b0), 23);
    run_vec(mk(IDL, 32'h0000_0000, 1'b0, 1'b0, IDL, 32'h0000_0044, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IDL, 32'h0000_0044, 1'b0, 1'b1), 24);

    // Locked core sequence of three transfers with the loader requesting
    run_vec(mk(NSQ, 32'h5000_0000, 1'b0, 1'b1, IDL, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, 32'h5000_0000, 1'b0, 1'b1), 30);
    run_vec(mk(NSQ, 32'h5000_0004, 1'b1, 1'b1, NSQ, 32'h0000_0050, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NSQ, 32'h5000_0004, 1'b1, 1'b0), 31);
    run_vec(mk(NSQ, 32'h5000_0008, 1'b0, 1'b1, NSQ, 32'h0000_0050, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NSQ, 32'h5000_0008, 1'b0, 1'b0), 32);
    run_vec(mk(IDL, 32'h5000_0008, 1'b0, 1'b1, NSQ, 32'h0000_0050, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDL, 32'h5000_0008, 1'b0, 1'b0), 33);
    run_vec(mk(IDL, 32'h0000_0000, 1'b0, 1'b0, NSQ, 32'h0000_0050, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, 32'h0000_0050, 1'b1, 1'b0), 34);
    // Loader data phase stretched by the slave with an error response pending
    run_vec(mk(IDL, 32'h0000_0000, 1'b0, 1'b0, NSQ, 32'h0000_0054, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, NSQ, 32'h0000_0054, 1'b1, 1'b1), 35);

    // Asynchronous reset in the middle of that data phase, no clock edge in between
    #1;
    HRESETn = 1'b0;
    #1;
    chk("async_rst_grant",   35, 32'(GRANT),     32'd0);
    chk("async_rst_m1_resp", 35, 32'(M1_HRESP),  32'd0);
    chk("async_rst_m1_rdy",  35, 32'(M1_HREADY), 32'd0);
    chk("async_rst_s_haddr", 35, S_HADDR,        32'h0000_0000);
    chk("async_rst_s_hwdata",35, S_HWDATA,       {16'hC0C0, 16'd35});
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Arbitration policy when both masters request at a loader switch point
    run_vec(mk(IDL, 32'h0000_0000, 1'b0, 1'b0, NSQ, 32'h0000_0060, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, 32'h0000_0060, 1'b1, 1'b0), 40);
    run_vec(mk(IDL, 32'h0000_0000, 1'b0, 1'b0, IDL, 32'h0000_0064, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IDL, 32'h0000_0064, 1'b0, 1'b1), 41);
`ifdef MFP_ARB_ROUND_ROBIN_EN
    run_vec(mk(NSQ, 32'h7000_0000, 1'b0, 1'b0, NSQ, 32'h0000_0068, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NSQ, 32'h7000_0000, 1'b0, 1'b1), 42);
    run_vec(mk(IDL, 32'h0000_0000, 1'b0, 1'b0, NSQ, 32'h0000_0068, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, 32'h0000_0068, 1'b1, 1'b0), 43);
`else
    run_vec(mk(NSQ, 32'h7000_0000, 1'b0, 1'b0, NSQ, 32'h0000_0068, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NSQ, 32'h0000_0068, 1'b1, 1'b1), 42);
    run_vec(mk(NSQ, 32'h7000_0000, 1'b0, 1'b0, IDL, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NSQ, 32'h7000_0000, 1'b0, 1'b1), 43);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
